// File: rtl/commit_checker_pkg.sv
// commit_checker_pkg: state encoding and failure codes shared by the commit checker.
package commit_checker_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_e;
  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_VALUE   = 2'b01;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b10;
endpackage

// File: rtl/commit_checker_if.sv
// commit_checker_if: config, writeback, register-file and status signals of the commit checker.
interface commit_checker_if #(
  parameter int NUM_CHECKS = 4,
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int RIDX_W     = 5,
  parameter int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
);
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [PC_W-1:0]   cfg_pc;
  logic [RIDX_W-1:0] cfg_ridx;
  logic [DATA_W-1:0] cfg_val;
  logic [IDX_W:0]    cfg_num;
  logic              start;
  logic              wb_valid;
  logic [PC_W-1:0]   wb_pc;
  logic [RIDX_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              done;
  logic              pass;
  logic [1:0]        fail_code;
  logic [IDX_W-1:0]  fail_idx;
  logic [31:0]       cycles;
  modport slave (
    input  cfg_we, cfg_idx, cfg_pc, cfg_ridx, cfg_val, cfg_num, start, wb_valid, wb_pc, rf_rdata,
    output rf_raddr, done, pass, fail_code, fail_idx, cycles
  );
  modport master (
    output cfg_we, cfg_idx, cfg_pc, cfg_ridx, cfg_val, cfg_num, start, wb_valid, wb_pc, rf_rdata,
    input  rf_raddr, done, pass, fail_code, fail_idx, cycles
  );
endinterface

// File: rtl/commit_checker_tbl.sv
// commit_checker_tbl: checkpoint table (pc, register index, expected value) with one write port and reads at cur.
module commit_checker_tbl #(
  parameter int NUM_CHECKS = 4,
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int RIDX_W     = 5,
  parameter int IDX_W      = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [PC_W-1:0]   wpc,
  input  logic [RIDX_W-1:0] wridx,
  input  logic [DATA_W-1:0] wval,
  input  logic [IDX_W-1:0]  cur,
  output logic [PC_W-1:0]   rd_pc,
  output logic [RIDX_W-1:0] rd_ridx,
  output logic [DATA_W-1:0] rd_val
);
  logic [PC_W-1:0]   pc_q   [NUM_CHECKS];
  logic [PC_W-1:0]   pc_d   [NUM_CHECKS];
  logic [RIDX_W-1:0] ridx_q [NUM_CHECKS];
  logic [RIDX_W-1:0] ridx_d [NUM_CHECKS];
  logic [DATA_W-1:0] val_q  [NUM_CHECKS];
  logic [DATA_W-1:0] val_d  [NUM_CHECKS];
  always_comb begin
    pc_d   = pc_q;
    ridx_d = ridx_q;
    val_d  = val_q;
    if (we && {1'b0, widx} < (IDX_W+1)'(NUM_CHECKS)) begin
      pc_d[widx]   = wpc;
      ridx_d[widx] = wridx;
      val_d[widx]  = wval;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q   <= '{default: '0};
      ridx_q <= '{default: '0};
      val_q  <= '{default: '0};
    end else begin
      pc_q   <= pc_d;
      ridx_q <= ridx_d;
      val_q  <= val_d;
    end
  end
  assign rd_pc   = pc_q[cur];
  assign rd_ridx = ridx_q[cur];
  assign rd_val  = val_q[cur];
endmodule

// File: rtl/commit_checker.sv
// commit_checker: watches writeback commits against an ordered checkpoint table and checks register values.
module commit_checker
  import commit_checker_pkg::*;
#(
  parameter int NUM_CHECKS = 4,
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int RIDX_W     = 5,
  parameter int TIMEOUT    = 100000,
  parameter int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input logic            clk,
  input logic            resetn,
  commit_checker_if.slave bus
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d, fidx_q, fidx_d;
  logic [IDX_W:0]   num_q, num_d;
  logic [31:0]      cycles_q, cycles_d;
  logic             done_q, done_d, pass_q, pass_d;
  logic [1:0]       code_q, code_d;
  logic [PC_W-1:0]  rd_pc;
  logic [DATA_W-1:0] rd_val;
  logic             run, timeout;
  commit_checker_tbl #(
    .NUM_CHECKS(NUM_CHECKS), .PC_W(PC_W), .DATA_W(DATA_W), .RIDX_W(RIDX_W), .IDX_W(IDX_W)
  ) u_tbl (
    .clk(clk), .resetn(resetn), .we(bus.cfg_we && !run), .widx(bus.cfg_idx), .wpc(bus.cfg_pc),
    .wridx(bus.cfg_ridx), .wval(bus.cfg_val), .cur(cur_q), .rd_pc(rd_pc), .rd_ridx(bus.rf_raddr),
    .rd_val(rd_val)
  );
  assign run     = state_q == S_RUN || state_q == S_CHECK;
  assign timeout = run && cycles_q == 32'(TIMEOUT - 1);
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    num_d    = num_q;
    fidx_d   = fidx_q;
    done_d   = done_q;
    pass_d   = pass_q;
    code_d   = code_q;
    cycles_d = run ? ((&cycles_q) ? cycles_q : cycles_q + 32'd1) : cycles_q;
    if (!run && bus.start) begin
      cycles_d = '0;
      cur_d    = '0;
      fidx_d   = '0;
      num_d    = bus.cfg_num;
      done_d   = bus.cfg_num == '0 || bus.cfg_num > (IDX_W+1)'(NUM_CHECKS);
      pass_d   = bus.cfg_num == '0;
      code_d   = bus.cfg_num > (IDX_W+1)'(NUM_CHECKS) ? FAIL_VALUE : FAIL_NONE;
      state_d  = done_d ? S_DONE : S_RUN;
    end else if (timeout) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      code_d  = FAIL_TIMEOUT;
      fidx_d  = cur_q;
    end else if (state_q == S_RUN && bus.wb_valid && bus.wb_pc == rd_pc) begin
      state_d = S_CHECK;
    end else if (state_q == S_CHECK) begin
      // rf_rdata now reflects the register addressed during the matching RUN cycle
      if (bus.rf_rdata != rd_val) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        code_d  = FAIL_VALUE;
        fidx_d  = cur_q;
      end else if ({1'b0, cur_q} == num_q - 1'b1) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        pass_d  = 1'b1;
      end else begin
        cur_d   = cur_q + 1'b1;
        state_d = S_RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      num_q    <= '0;
      fidx_q   <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      code_q   <= FAIL_NONE;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      num_q    <= num_d;
      fidx_q   <= fidx_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      code_q   <= code_d;
    end
  end
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_code = code_q;
  assign bus.fail_idx  = fidx_q;
  assign bus.cycles    = cycles_q;
endmodule

// File: doc/commit_checker.md
COMMIT_CHECKER -- requirements
Module: commit_checker

Interface
REQ-001 Parameter NUM_CHECKS, default 4, number of checkpoint table entries (1..16).
REQ-002 Parameter PC_W, default 32, writeback PC width.
REQ-003 Parameter DATA_W, default 32, register data width.
REQ-004 Parameter RIDX_W, default 5, register index width.
REQ-005 Parameter TIMEOUT, default 100000, run-cycle limit before timeout failure.
REQ-006 Parameter IDX_W, default $clog2(NUM_CHECKS) (minimum 1), table index width.
REQ-007 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  table entry to write.
- cfg_pc  in  PC_W  checkpoint PC.
- cfg_ridx  in  RIDX_W  register index to check.
- cfg_val  in  DATA_W  expected register value.
- cfg_num  in  IDX_W+1  active checkpoint count; sampled on start.
- start  in  1  one-cycle run request.
- wb_valid  in  1  writeback-stage instruction valid.
- wb_pc  in  PC_W  writeback-stage PC.
- rf_raddr  out  RIDX_W  register-file read index.
- rf_rdata  in  DATA_W  register-file data; valid one cycle after rf_raddr.
- done  out  1  run finished (sticky).
- pass  out  1  run passed (valid when done).
- fail_code  out  2  00 none, 01 value mismatch, 10 timeout.
- fail_idx  out  IDX_W  checkpoint index at failure.
- cycles  out  32  cycles elapsed in current/last run, saturating.

Function
REQ-008 States: IDLE, RUN, CHECK, DONE.
REQ-009 cfg_we writes entry cfg_idx only in IDLE or DONE; ignored in RUN/CHECK; cfg_idx >= NUM_CHECKS ignored.
REQ-010 IDLE/DONE + start, cfg_num in 1..NUM_CHECKS: latch cfg_num, cur=0, cycles=0, clear done/pass/fail_code/fail_idx, next state RUN.
REQ-011 IDLE/DONE + start, cfg_num==0: next cycle DONE, done=1, pass=1.
REQ-012 IDLE/DONE + start, cfg_num > NUM_CHECKS: next cycle DONE, done=1, pass=0, fail_code=01, fail_idx=0.
REQ-013 start in RUN/CHECK ignored.
REQ-014 rf_raddr = ridx[cur] combinationally in every state.
REQ-015 RUN: wb_valid && wb_pc==pc[cur] -> CHECK next cycle; non-matching or invalid commits ignored; checkpoints matched strictly in order.
REQ-016 CHECK (exactly one cycle): rf_rdata==val[cur] and cur==num-1 -> DONE, pass=1; equal and not last -> cur+1, RUN; unequal -> DONE, pass=0, fail_code=01, fail_idx=cur.
REQ-017 cycles increments by 1 each cycle in RUN/CHECK, saturates at 2^32-1, holds in IDLE/DONE.
REQ-018 RUN/CHECK with cycles==TIMEOUT-1 -> DONE, fail_code=10, fail_idx=cur; timeout has priority over match/compare in the same cycle.
REQ-019 done, pass, fail_code, fail_idx are registered and hold until next accepted start or reset.
REQ-020 Latency: matching commit to done = 2 cycles for last checkpoint.

Reset
REQ-021 resetn low asynchronously forces IDLE, cur=0, cycles=0, done=0, pass=0, fail_code=00, fail_idx=0.
REQ-022 Table contents cleared to zero on reset; reset mid-run aborts with no done pulse.

Structure
REQ-023 Package commit_checker_pkg holds state encoding and fail_code constants.
REQ-024 Checkpoint table in one sub-module commit_checker_tbl (write port, three read ports at cur); FSM, counter and compare in commit_checker.

Verification
REQ-025 num=1, entry0 pc=0x1c000050 ridx=5 val=0x5a; commit 0x1c000050 with regs[5]=0x5a -> done=1, pass=1, 2 cycles after commit.
REQ-026 Same, regs[5]=0x5b -> done=1, pass=0, fail_code=01, fail_idx=0.
REQ-027 num=3, pcs 0x100/0x200/0x300 committed out of order (0x200 first) then in order, all values correct -> 0x200 ignored first time, pass=1.
REQ-028 TIMEOUT=50, no matching commit -> done at cycles==49 +1, fail_code=10, fail_idx=0.
REQ-029 Timeout coinciding with CHECK of last entry -> fail_code=10; start in RUN and cfg_we in RUN ignored.
REQ-030 resetn asserted mid-RUN -> all outputs zero immediately; new start after reset with reloaded table passes.
